// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage hazard detection, branch flush and memory freeze.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             hazard,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // Producers in EXE (E) and MEM (M); WB is not tracked since it writes first.
  logic       r_e_v;
  logic [3:0] r_e_dest;
  logic       r_e_ld;
  logic       r_m_v;
  logic [3:0] r_m_dest;
  logic [CNT_W-1:0] r_cnt;

  logic w_match_e;
  logic w_match_m;
  logic w_hazard;

  always_comb begin
    w_match_e = r_e_v & ((r_e_dest == src1) | (two_src & (r_e_dest == src2)));
    w_match_m = r_m_v & ((r_m_dest == src1) | (two_src & (r_m_dest == src2)));
    if (FWD_EN) begin
      w_hazard = w_match_e & r_e_ld;
    end else begin
      w_hazard = w_match_e | w_match_m;
    end
    // The ID instruction is being discarded by the flush, so it cannot stall.
    if (branch_taken) begin
      w_hazard = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_v    <= 1'b0;
      r_e_dest <= 4'd0;
      r_e_ld   <= 1'b0;
      r_m_v    <= 1'b0;
      r_m_dest <= 4'd0;
      r_cnt    <= '0;
    end else if (!mem_stall) begin
      r_m_v    <= r_e_v;
      r_m_dest <= r_e_dest;
      r_e_v    <= id_wb_en & ~w_hazard & ~branch_taken;
      r_e_dest <= id_dest;
      r_e_ld   <= id_mem_r_en;
      if (w_hazard && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign hazard    = w_hazard;
  assign flush     = branch_taken & ~mem_stall;
  assign freeze    = mem_stall;
  assign stall_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed scoreboard bench for hazard_scoreboard (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, id_dest;
  logic       two_src, id_wb_en, id_mem_r_en, branch_taken, mem_stall;

  logic        hz0, fl0, fz0, hz1, fl1, fz1, hz2, fl2, fz2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .hazard(hz0), .flush(fl0), .freeze(fz0), .stall_cnt(cnt0));

  hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .hazard(hz1), .flush(fl1), .freeze(fz1), .stall_cnt(cnt1));

  hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .hazard(hz2), .flush(fl2), .freeze(fz2), .stall_cnt(cnt2));

  typedef struct {
    string name;
    int    dut;
    logic  hz;
    logic  fl;
    logic  fz;
    int    cnt;   // -1: stall counter not checked this cycle
  } exp_t;

  exp_t exp_q[$];

  // Monitor: the DUT presents a new response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic a_hz, a_fl, a_fz;
      int   a_cnt;
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin a_hz = hz0; a_fl = fl0; a_fz = fz0; a_cnt = int'(cnt0); end
        1:       begin a_hz = hz1; a_fl = fl1; a_fz = fz1; a_cnt = int'(cnt1); end
        default: begin a_hz = hz2; a_fl = fl2; a_fz = fz2; a_cnt = int'(cnt2); end
      endcase
      checks = checks + 1;
      if (a_hz !== e.hz) begin
        errors = errors + 1;
        $display("FAIL %s hazard: got %b expected %b", e.name, a_hz, e.hz);
      end
      checks = checks + 1;
      if (a_fl !== e.fl) begin
        errors = errors + 1;
        $display("FAIL %s flush: got %b expected %b", e.name, a_fl, e.fl);
      end
      checks = checks + 1;
      if (a_fz !== e.fz) begin
        errors = errors + 1;
        $display("FAIL %s freeze: got %b expected %b", e.name, a_fz, e.fz);
      end
      if (e.cnt >= 0) begin
        checks = checks + 1;
        if (a_cnt != e.cnt) begin
          errors = errors + 1;
          $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, a_cnt, e.cnt);
        end
      end
    end
  end

  task automatic idle_inputs();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_wb_en = 1'b0;
    id_mem_r_en = 1'b0; id_dest = 4'd0; branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one ID-stage cycle and queue the response expected for it.
  task automatic cyc(input string nm, input int d,
                     input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                     input logic wb, input logic ld, input logic [3:0] dst,
                     input logic br, input logic ms,
                     input logic ehz, input logic efl, input logic efz, input int ecnt);
    exp_t e;
    if (rst === 1'b1) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    src1 = s1; src2 = s2; two_src = ts; id_wb_en = wb; id_mem_r_en = ld;
    id_dest = dst; branch_taken = br; mem_stall = ms;
    e.name = nm; e.dut = d; e.hz = ehz; e.fl = efl; e.fz = efz; e.cnt = ecnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    // Reset state
    cyc("reset_state",  0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // 1. ALU producer then dependent reader, no forwarding: 2-cycle stall
    do_reset();
    cyc("t1_add_r1",    0, 4'd0, 4'd0, 0, 1, 0, 4'd1, 0, 0,  0, 0, 0, 0);
    cyc("t1_sub_e",     0, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0,  1, 0, 0, 0);
    cyc("t1_sub_m",     0, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0,  1, 0, 0, 1);
    cyc("t1_sub_go",    0, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0,  0, 0, 0, 2);
    cyc("t1_after",     0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0,  0, 0, 0, 2);

    // 2. Second source only counts when two_src=1; R15 tracked normally
    do_reset();
    cyc("t2_mov_r3",    0, 4'd0, 4'd0, 0, 1, 0, 4'd3, 0, 0,  0, 0, 0, 0);
    cyc("t2_str_2src",  0, 4'd0, 4'd3, 1, 0, 0, 4'd3, 0, 0,  1, 0, 0, 0);
    do_reset();
    cyc("t2_mov_r3b",   0, 4'd0, 4'd0, 0, 1, 0, 4'd3, 0, 0,  0, 0, 0, 0);
    cyc("t2_str_1src",  0, 4'd0, 4'd3, 0, 0, 0, 4'd3, 0, 0,  0, 0, 0, 0);
    do_reset();
    cyc("t2_mov_r15",   0, 4'd0, 4'd0, 0, 1, 0, 4'd15, 0, 0, 0, 0, 0, 0);
    cyc("t2_rd_r15",    0, 4'd0, 4'd15, 1, 0, 0, 4'd0, 0, 0, 1, 0, 0, 0);

    // 3. Forwarding: load-use stalls 1 cycle, ALU producer never stalls
    do_reset();
    cyc("t3_ldr_r2",    1, 4'd0, 4'd0, 0, 1, 1, 4'd2, 0, 0,  0, 0, 0, 0);
    cyc("t3_use_stall", 1, 4'd2, 4'd0, 0, 1, 0, 4'd5, 0, 0,  1, 0, 0, 0);
    cyc("t3_use_go",    1, 4'd2, 4'd0, 0, 1, 0, 4'd5, 0, 0,  0, 0, 0, 1);
    cyc("t3_alu_r2",    1, 4'd0, 4'd0, 0, 1, 0, 4'd2, 0, 0,  0, 0, 0, 1);
    cyc("t3_alu_use",   1, 4'd2, 4'd0, 0, 1, 0, 4'd6, 0, 0,  0, 0, 0, 1);

    // 4. Branch beats a matching hazard; branch under mem_stall waits
    do_reset();
    cyc("t4_mov_r4",    0, 4'd0, 4'd0, 0, 1, 0, 4'd4, 0, 0,  0, 0, 0, 0);
    cyc("t4_br_match",  0, 4'd4, 4'd0, 0, 1, 0, 4'd6, 1, 0,  0, 1, 0, 0);
    cyc("t4_e_bubble",  0, 4'd6, 4'd0, 0, 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);
    do_reset();
    cyc("t4b_mov_r4",   0, 4'd0, 4'd0, 0, 1, 0, 4'd4, 0, 0,  0, 0, 0, 0);
    cyc("t4b_br_frz",   0, 4'd4, 4'd0, 0, 1, 0, 4'd7, 1, 1,  0, 0, 1, 0);
    cyc("t4b_br_go",    0, 4'd4, 4'd0, 0, 1, 0, 4'd7, 1, 0,  0, 1, 0, 0);
    cyc("t4b_after",    0, 4'd7, 4'd0, 0, 0, 0, 4'd0, 0, 0,  0, 0, 0, 0);

    // 5. mem_stall freezes the scoreboard and counter, then the stall resumes
    do_reset();
    cyc("t5_mov_r5",    0, 4'd0, 4'd0, 0, 1, 0, 4'd5, 0, 0,  0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("t5_frozen",  0, 4'd5, 4'd0, 0, 1, 0, 4'd8, 0, 1,  1, 0, 1, 0);
    cyc("t5_rel_e",     0, 4'd5, 4'd0, 0, 1, 0, 4'd8, 0, 0,  1, 0, 0, 0);
    cyc("t5_rel_m",     0, 4'd5, 4'd0, 0, 1, 0, 4'd8, 0, 0,  1, 0, 0, 1);
    cyc("t5_rel_go",    0, 4'd5, 4'd0, 0, 1, 0, 4'd8, 0, 0,  0, 0, 0, 2);

    // 6. Reset in the middle of a stall
    do_reset();
    cyc("t6_mov_r1",    0, 4'd0, 4'd0, 0, 1, 0, 4'd1, 0, 0,  0, 0, 0, 0);
    cyc("t6_stall",     0, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0,  1, 0, 0, 0);
    do_reset();
    cyc("t6_post_rst",  0, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0,  0, 0, 0, 0);

    // 6b. 2-bit counter saturates after repeated self-dependent stalls
    do_reset();
    cyc("t6b_c1",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  0, 0, 0, 0);
    cyc("t6b_c2",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 0);
    cyc("t6b_c3",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 1);
    cyc("t6b_c4",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  0, 0, 0, 2);
    cyc("t6b_c5",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 2);
    cyc("t6b_c6",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 3);
    cyc("t6b_c7",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  0, 0, 0, 3);
    cyc("t6b_c8",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 3);
    cyc("t6b_c9",       2, 4'd1, 4'd0, 0, 1, 0, 4'd1, 0, 0,  1, 0, 0, 3);
    cyc("t6b_sat",      2, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0,  0, 0, 0, 3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
